uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Framed-packet deframer placed directly downstream of `uart_rx_wrap`. It consumes the received byte stream on an AXIS slave port, hunts for start-of-frame, and validates length and checksum. Each good payload goes out as one AXIS packet with `tlast`; bad or timed-out frames are discarded. Output feeds command logic or loops back to `uart_tx`.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per frame (1..255); sets buffer depth.
- `SOF`, 8'hA5: start-of-frame byte.
- `TIMEOUT_CLKS`, 16*10*CLKS_PER_BIT (2560 at 16 clk/bit): idle cycles allowed between bytes inside a frame.
- `i_clk`  in  1  sole clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_s_axis_tvalid`  in  1  byte valid from `uart_rx_wrap`.
- `o_s_axis_tready`  out  1  parser accepts a byte.
- `i_s_axis_tdata`  in  8  received byte.
- `o_m_axis_tvalid`  out  1  payload byte valid.
- `i_m_axis_tready`  in  1  downstream accepts.
- `o_m_axis_tdata`  out  8  payload byte.
- `o_m_axis_tlast`  out  1  last payload byte of frame.
- `o_frame_ok`  out  1  one-cycle pulse when a frame passes its checksum.
- `o_frame_err`  out  1  one-cycle pulse when a frame is discarded.
- `o_err_code`  out  2  cause, valid with `o_frame_err`: 1 = bad length, 2 = bad checksum, 3 = timeout. Holds its value until the next error.

## Operation
- Frame on the wire: `SOF`, `LEN`, `LEN` payload bytes, `CHK`.
- Frame is good when (LEN + sum(payload) + CHK) mod 256 == 0.
- States:
  - HUNT: discard non-`SOF` bytes. On `SOF` -> LEN.
  - LEN: LEN == 0 or LEN > `MAX_LEN` -> error code 1, then HUNT. Otherwise latch LEN, seed sum = LEN -> PAYLOAD.
  - PAYLOAD: write each byte to the buffer at the write index and add it to the 8-bit sum. After LEN bytes -> CHK.
  - CHK: sum + CHK == 0 -> pulse `o_frame_ok`, go to DRAIN. Otherwise error code 2, then HUNT.
  - DRAIN: output buffer bytes 0..LEN-1 in order. `tlast` is set on byte LEN-1. After that handshake -> HUNT.
- A byte equal to `SOF` inside LEN/PAYLOAD/CHK is treated as data. There is no resync mid-frame.
- Timeout:
  - Counter clears on every accepted byte and counts while in LEN, PAYLOAD or CHK.
  - Reaching `TIMEOUT_CLKS` -> error code 3, then HUNT. Partial payload is dropped.
- Sum and indices wrap mod 256. Index width is clog2(`MAX_LEN`).

## Timing
- Reset values:
  - State = HUNT; `o_s_axis_tready` = 1.
  - `o_m_axis_tvalid`, `o_m_axis_tlast`, `o_frame_ok`, `o_frame_err` = 0.
  - `o_m_axis_tdata` = 0, `o_err_code` = 0.
- `o_s_axis_tready` = 1 in HUNT/LEN/PAYLOAD/CHK and 0 in DRAIN. A byte is accepted only when tvalid && tready on a rising edge.
- `o_frame_ok` pulses in the cycle after `CHK` is accepted. The first `o_m_axis_tvalid` is asserted in that same cycle.
- Error pulse occurs the cycle after the offending byte, or the cycle after the timeout count is reached. State is HUNT in that cycle, so the next byte can be accepted immediately.
- Output: once tvalid is high, tdata/tlast hold until handshake. Sustains one byte per clock with `i_m_axis_tready` held high (buffer read prefetch required).
- Latency: last input byte (`CHK`) to first output byte = 1 cycle.
- A frame of LEN bytes drains in LEN cycles minimum.
- `i_rst` at any point, including mid-DRAIN: outputs return to reset values immediately; the buffered frame is lost with no `tlast`.

## Structure
- Package `uart_pkg`:
  - state enum `frame_state_t` {HUNT, LEN, PAYLOAD, CHK, DRAIN};
  - error-code constants `ERR_LEN` = 1, `ERR_CHK` = 2, `ERR_TMO` = 3;
  - default `SOF` constant.
- One sub-module: `uart_frame_buf`, a simple dual-port `MAX_LEN`x8 register buffer with a synchronous write port and a combinational read port. Parser FSM, sum, timeout counter and output register stay in `uart_frame_parser`.

## Test plan
- Good frame: A5 03 11 22 33 97 -> outputs 11, 22, 33 with tlast on 33; one `o_frame_ok` pulse; no error.
- Bad checksum: A5 03 11 22 33 98 -> no output tvalid; `o_frame_err` pulse with `o_err_code` = 2; a following good frame passes.
- Length errors: A5 00, and A5 11 with `MAX_LEN` = 16 -> `o_err_code` = 1 each time; the next byte is hunted as SOF.
- Garbage then frame: 00 FF 5A A5 01 A5 5A -> single output byte A5 with tlast. A5 inside the payload is data.
- Timeout: A5 02 11, then idle for `TIMEOUT_CLKS` -> `o_err_code` = 3; partial frame discarded.
- Backpressure and reset: toggle `i_m_axis_tready` randomly during DRAIN -> data stable and order preserved; `o_s_axis_tready` = 0 throughout. Assert `i_rst` mid-DRAIN -> tvalid = 0 next edge and the state returns to HUNT.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART framed-packet deframer.
package uart_pkg;

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DRAIN} frame_state_t;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: registered write on w_clk, combinational read so the parser can prefetch.
// No reset on storage; contents are only read after being written within the same frame.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             w_clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge w_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Deframes SOF/LEN/payload/CHK from an AXIS byte stream; good payloads leave as one AXIS packet.
// First output byte one cycle after CHK; input stalls (tready=0) only while a frame drains.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF          = SOF_DEFAULT,
  parameter int         TIMEOUT_CLKS = 2560
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_s_axis_tvalid,
  output logic       o_s_axis_tready,
  input  logic [7:0] i_s_axis_tdata,
  output logic       o_m_axis_tvalid,
  input  logic       i_m_axis_tready,
  output logic [7:0] o_m_axis_tdata,
  output logic       o_m_axis_tlast,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code
);

  localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int               TMO_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

  frame_state_t     state_q, state_d;
  logic [7:0]       len_q, sum_q, wr_cnt_q, rd_cnt_q;
  logic [7:0]       chk_sum, buf_rdata;
  logic [TMO_W-1:0] tmo_q;
  logic             accept, in_frame, tmo_hit, len_bad, m_hs;
  logic             ok_set, err_set;
  logic [1:0]       err_code_d;

  assign accept   = i_s_axis_tvalid && o_s_axis_tready;
  assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  assign tmo_hit  = in_frame && !accept && (tmo_q == TMO_LAST);
  assign len_bad  = (i_s_axis_tdata == 8'd0) || (i_s_axis_tdata > MAX_LEN_B);
  assign chk_sum  = sum_q + i_s_axis_tdata;
  assign m_hs     = o_m_axis_tvalid && i_m_axis_tready;

  uart_frame_buf #(.DEPTH(MAX_LEN), .IDX_W(IDX_W)) u_buf (
    .w_clk (i_clk),
    .we    ((state_q == PAYLOAD) && accept),
    .waddr (wr_cnt_q[IDX_W-1:0]),
    .wdata (i_s_axis_tdata),
    .raddr (rd_cnt_q[IDX_W-1:0]),
    .rdata (buf_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT:    if (accept && (i_s_axis_tdata == SOF)) state_d = LEN;
        LEN:     if (accept) state_d = len_bad ? HUNT : PAYLOAD;
        PAYLOAD: if (accept && (wr_cnt_q == len_q - 8'd1)) state_d = CHK;
        CHK:     if (accept) state_d = (chk_sum == 8'd0) ? DRAIN : HUNT;
        DRAIN:   if (m_hs && o_m_axis_tlast) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    o_s_axis_tready = (state_q != DRAIN);
    ok_set          = 1'b0;
    err_set         = 1'b0;
    err_code_d      = ERR_LEN;
    if (tmo_hit) begin
      err_set    = 1'b1;
      err_code_d = ERR_TMO;
    end else if ((state_q == LEN) && accept && len_bad) begin
      err_set    = 1'b1;
      err_code_d = ERR_LEN;
    end else if ((state_q == CHK) && accept) begin
      if (chk_sum == 8'd0) begin
        ok_set = 1'b1;
      end else begin
        err_set    = 1'b1;
        err_code_d = ERR_CHK;
      end
    end
  end

  // Output register is loaded from the combinational buffer read, so the next byte is ready at each handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len_q           <= '0;
      sum_q           <= '0;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      tmo_q           <= '0;
      o_m_axis_tvalid <= 1'b0;
      o_m_axis_tdata  <= '0;
      o_m_axis_tlast  <= 1'b0;
      o_frame_ok      <= 1'b0;
      o_frame_err     <= 1'b0;
      o_err_code      <= '0;
    end else begin
      o_frame_ok  <= ok_set;
      o_frame_err <= err_set;
      if (err_set) o_err_code <= err_code_d;
      tmo_q <= (in_frame && !accept) ? tmo_q + 1'b1 : '0;

      if ((state_q == LEN) && accept) begin
        len_q    <= i_s_axis_tdata;
        sum_q    <= i_s_axis_tdata;
        wr_cnt_q <= '0;
        rd_cnt_q <= '0;
      end
      if ((state_q == PAYLOAD) && accept) begin
        sum_q    <= chk_sum;
        wr_cnt_q <= wr_cnt_q + 8'd1;
      end

      if (ok_set) begin
        o_m_axis_tvalid <= 1'b1;
        o_m_axis_tdata  <= buf_rdata;
        o_m_axis_tlast  <= (len_q == 8'd1);
        rd_cnt_q        <= 8'd1;
      end else if (m_hs) begin
        if (o_m_axis_tlast) begin
          o_m_axis_tvalid <= 1'b0;
          o_m_axis_tlast  <= 1'b0;
        end else begin
          o_m_axis_tdata  <= buf_rdata;
          o_m_axis_tlast  <= (rd_cnt_q == len_q - 8'd1);
          rd_cnt_q        <= rd_cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: framing, errors, timeout, backpressure and reset.
module tb_uart_frame_parser;

  localparam int TMO = 2560;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_s_axis_tvalid = 1'b0;
  logic [7:0] i_s_axis_tdata = 8'h00;
  logic       i_m_axis_tready = 1'b1;
  logic       o_s_axis_tready, o_m_axis_tvalid, o_m_axis_tlast, o_frame_ok, o_frame_err;
  logic [7:0] o_m_axis_tdata;
  logic [1:0] o_err_code;

  uart_frame_parser #(.MAX_LEN(16), .SOF(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_s_axis_tvalid (i_s_axis_tvalid),
    .o_s_axis_tready (o_s_axis_tready),
    .i_s_axis_tdata  (i_s_axis_tdata),
    .o_m_axis_tvalid (o_m_axis_tvalid),
    .i_m_axis_tready (i_m_axis_tready),
    .o_m_axis_tdata  (o_m_axis_tdata),
    .o_m_axis_tlast  (o_m_axis_tlast),
    .o_frame_ok      (o_frame_ok),
    .o_frame_err     (o_frame_err),
    .o_err_code      (o_err_code)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int passes = 0;

  // Negedge monitor: collects output beats {tlast,tdata} and event counts.
  logic [8:0] out_q[$];
  int         ok_cnt = 0, err_cnt = 0, stall_viol = 0, rdy_in_drain = 0;
  logic [1:0] last_code = 2'd0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = 9'd0;

  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!o_m_axis_tvalid || ({o_m_axis_tlast, o_m_axis_tdata} != prev_out)))
        stall_viol++;
      prev_stall = o_m_axis_tvalid && !i_m_axis_tready;
      prev_out   = {o_m_axis_tlast, o_m_axis_tdata};
      if (o_m_axis_tvalid && i_m_axis_tready) out_q.push_back({o_m_axis_tlast, o_m_axis_tdata});
      if (o_m_axis_tvalid && o_s_axis_tready) rdy_in_drain++;
      if (o_frame_ok) ok_cnt++;
      if (o_frame_err) begin
        err_cnt++;
        last_code = o_err_code;
      end
    end
  end

  // Tasks start and end on a rising edge; inputs change 1 time unit after it.
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    #1;
    i_s_axis_tvalid = 1'b1;
    i_s_axis_tdata  = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge i_clk);
      acc = o_s_axis_tready;
      @(posedge i_clk);
    end
    if (!acc) begin
      checks++;
      $display("FAIL send_byte_%h: tready got 0, need 1 within 100 cycles", b);
    end
  endtask

  task automatic idle(input int n);
    #1;
    i_s_axis_tvalid = 1'b0;
    repeat (n) @(posedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (o_s_axis_tready !== 1'b1) $display("FAIL rst_s_tready: got %b need 1", o_s_axis_tready); else passes++;
    checks++; if (o_m_axis_tvalid !== 1'b0) $display("FAIL rst_m_tvalid: got %b need 0", o_m_axis_tvalid); else passes++;
    checks++; if (o_m_axis_tlast !== 1'b0) $display("FAIL rst_m_tlast: got %b need 0", o_m_axis_tlast); else passes++;
    checks++; if (o_m_axis_tdata !== 8'h00) $display("FAIL rst_m_tdata: got %h need 00", o_m_axis_tdata); else passes++;
    checks++; if (o_frame_ok !== 1'b0) $display("FAIL rst_frame_ok: got %b need 0", o_frame_ok); else passes++;
    checks++; if (o_frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b need 0", o_frame_err); else passes++;
    checks++; if (o_err_code !== 2'd0) $display("FAIL rst_err_code: got %0d need 0", o_err_code); else passes++;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk);
  endtask

  task automatic test_good_frame();
    int base, okb, errb;
    logic [8:0] got;
    logic [8:0] exp_b [3] = '{9'h011, 9'h022, 9'h133};
    base = out_q.size(); okb = ok_cnt; errb = err_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    #1 i_s_axis_tvalid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_frame_ok !== 1'b1) $display("FAIL good_ok_latency: got %b need 1", o_frame_ok); else passes++;
    checks++; if (o_m_axis_tvalid !== 1'b1) $display("FAIL good_tvalid_latency: got %b need 1", o_m_axis_tvalid); else passes++;
    checks++; if (o_m_axis_tdata !== 8'h11) $display("FAIL good_first_byte: got %h need 11", o_m_axis_tdata); else passes++;
    checks++; if (o_s_axis_tready !== 1'b0) $display("FAIL good_s_tready_drain: got %b need 0", o_s_axis_tready); else passes++;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_m_axis_tvalid !== 1'b0) $display("FAIL good_drain_len: tvalid got %b need 0", o_m_axis_tvalid); else passes++;
    checks++; if (o_s_axis_tready !== 1'b1) $display("FAIL good_back_to_hunt: s_tready got %b need 1", o_s_axis_tready); else passes++;
    @(posedge i_clk);
    checks++; if (out_q.size() - base != 3) $display("FAIL good_count: got %0d need 3", out_q.size() - base); else passes++;
    for (int i = 0; i < 3; i++) begin
      got = (base + i < out_q.size()) ? out_q[base + i] : 9'h1FF;
      checks++; if (got !== exp_b[i]) $display("FAIL good_byte%0d: got %h need %h", i, got, exp_b[i]); else passes++;
    end
    checks++; if (ok_cnt - okb != 1) $display("FAIL good_ok_count: got %0d need 1", ok_cnt - okb); else passes++;
    checks++; if (err_cnt != errb) $display("FAIL good_no_err: got %0d need 0", err_cnt - errb); else passes++;
  endtask

  task automatic test_bad_chk();
    int base, okb, errb;
    logic [8:0] got;
    base = out_q.size(); okb = ok_cnt; errb = err_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h98);
    #1 i_s_axis_tvalid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_frame_err !== 1'b1) $display("FAIL chk_err_pulse: got %b need 1", o_frame_err); else passes++;
    checks++; if (o_err_code !== 2'd2) $display("FAIL chk_err_code: got %0d need 2", o_err_code); else passes++;
    checks++; if (o_m_axis_tvalid !== 1'b0) $display("FAIL chk_no_output: tvalid got %b need 0", o_m_axis_tvalid); else passes++;
    @(posedge i_clk);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'hBD);
    idle(4);
    got = (base < out_q.size()) ? out_q[base] : 9'h1FF;
    checks++; if (out_q.size() - base != 1) $display("FAIL chk_next_count: got %0d need 1", out_q.size() - base); else passes++;
    checks++; if (got !== 9'h142) $display("FAIL chk_next_byte: got %h need 142", got); else passes++;
    checks++; if (ok_cnt - okb != 1) $display("FAIL chk_next_ok: got %0d need 1", ok_cnt - okb); else passes++;
    checks++; if (err_cnt - errb != 1) $display("FAIL chk_err_count: got %0d need 1", err_cnt - errb); else passes++;
  endtask

  task automatic test_len_err();
    int base, okb, errb;
    logic [8:0] got;
    logic [8:0] exp_b [2] = '{9'h001, 9'h102};
    base = out_q.size(); okb = ok_cnt; errb = err_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    #1 i_s_axis_tvalid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_frame_err !== 1'b1) $display("FAIL len0_err_pulse: got %b need 1", o_frame_err); else passes++;
    checks++; if (o_err_code !== 2'd1) $display("FAIL len0_err_code: got %0d need 1", o_err_code); else passes++;
    @(posedge i_clk);
    // LEN 0x11 exceeds MAX_LEN; the SOF right behind it must be hunted with no gap.
    send_byte(8'hA5); send_byte(8'h11);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'hFB);
    idle(5);
    checks++; if (err_cnt - errb != 2) $display("FAIL len_err_count: got %0d need 2", err_cnt - errb); else passes++;
    checks++; if (last_code !== 2'd1) $display("FAIL len17_err_code: got %0d need 1", last_code); else passes++;
    checks++; if (out_q.size() - base != 2) $display("FAIL len_next_count: got %0d need 2", out_q.size() - base); else passes++;
    for (int i = 0; i < 2; i++) begin
      got = (base + i < out_q.size()) ? out_q[base + i] : 9'h1FF;
      checks++; if (got !== exp_b[i]) $display("FAIL len_next_byte%0d: got %h need %h", i, got, exp_b[i]); else passes++;
    end
    checks++; if (ok_cnt - okb != 1) $display("FAIL len_next_ok: got %0d need 1", ok_cnt - okb); else passes++;
  endtask

  task automatic test_garbage();
    int base, okb, errb;
    logic [8:0] got;
    base = out_q.size(); okb = ok_cnt; errb = err_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'h5A);
    idle(4);
    got = (base < out_q.size()) ? out_q[base] : 9'h1FF;
    checks++; if (out_q.size() - base != 1) $display("FAIL garbage_count: got %0d need 1", out_q.size() - base); else passes++;
    checks++; if (got !== 9'h1A5) $display("FAIL garbage_sof_as_data: got %h need 1a5", got); else passes++;
    checks++; if (ok_cnt - okb != 1) $display("FAIL garbage_ok: got %0d need 1", ok_cnt - okb); else passes++;
    checks++; if (err_cnt != errb) $display("FAIL garbage_no_err: got %0d need 0", err_cnt - errb); else passes++;
  endtask

  task automatic test_timeout();
    int base, okb, k;
    bit seen;
    logic [8:0] got;
    base = out_q.size(); okb = ok_cnt; seen = 1'b0; k = 0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    #1 i_s_axis_tvalid = 1'b0;
    while (!seen && k < TMO + 20) begin
      @(negedge i_clk);
      k++;
      seen = o_frame_err;
    end
    checks++; if (!seen) $display("FAIL tmo_pulse: no err after %0d cycles, need one near %0d", k, TMO); else passes++;
    checks++; if (k < TMO || k > TMO + 2) $display("FAIL tmo_delay: got %0d cycles need %0d..%0d", k, TMO, TMO + 2); else passes++;
    checks++; if (o_err_code !== 2'd3) $display("FAIL tmo_err_code: got %0d need 3", o_err_code); else passes++;
    @(posedge i_clk);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'hBD);
    idle(4);
    got = (base < out_q.size()) ? out_q[base] : 9'h1FF;
    checks++; if (out_q.size() - base != 1) $display("FAIL tmo_partial_dropped: count got %0d need 1", out_q.size() - base); else passes++;
    checks++; if (got !== 9'h142) $display("FAIL tmo_recover_byte: got %h need 142", got); else passes++;
    checks++; if (ok_cnt - okb != 1) $display("FAIL tmo_ok_count: got %0d need 1", ok_cnt - okb); else passes++;
  endtask

  task automatic test_backpressure_reset();
    int base, okb, sb, rb;
    logic [8:0] got, want;
    base = out_q.size(); okb = ok_cnt; sb = stall_viol; rb = rdy_in_drain;
    // MAX_LEN payload 01..10: 0x10 + 0x88 = 0x98, so CHK = 0x68.
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h68);
    #1 i_s_axis_tvalid = 1'b0;
    for (int c = 0; c < 400 && (out_q.size() - base) < 16; c++) begin
      i_m_axis_tready = 1'($urandom_range(0, 1));
      @(posedge i_clk);
      #1;
    end
    i_m_axis_tready = 1'b1;
    repeat (2) @(posedge i_clk);
    checks++; if (out_q.size() - base != 16) $display("FAIL bp_count: got %0d need 16", out_q.size() - base); else passes++;
    for (int i = 0; i < 16; i++) begin
      got  = (base + i < out_q.size()) ? out_q[base + i] : 9'h1FF;
      want = {(i == 15), 8'(i + 1)};
      checks++; if (got !== want) $display("FAIL bp_byte%0d: got %h need %h", i, got, want); else passes++;
    end
    checks++; if (stall_viol != sb) $display("FAIL bp_hold_stable: got %0d changes need 0", stall_viol - sb); else passes++;
    checks++; if (rdy_in_drain != rb) $display("FAIL bp_s_tready_low: got %0d ready cycles need 0", rdy_in_drain - rb); else passes++;
    checks++; if (ok_cnt - okb != 1) $display("FAIL bp_ok: got %0d need 1", ok_cnt - okb); else passes++;

    #1 i_m_axis_tready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    idle(2);
    @(negedge i_clk);
    checks++; if (o_m_axis_tvalid !== 1'b1) $display("FAIL rst_pre_drain: tvalid got %b need 1", o_m_axis_tvalid); else passes++;
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    checks++; if (o_m_axis_tvalid !== 1'b0) $display("FAIL rst_mid_tvalid: got %b need 0", o_m_axis_tvalid); else passes++;
    checks++; if (o_m_axis_tlast !== 1'b0) $display("FAIL rst_mid_tlast: got %b need 0", o_m_axis_tlast); else passes++;
    checks++; if (o_s_axis_tready !== 1'b1) $display("FAIL rst_mid_s_tready: got %b need 1", o_s_axis_tready); else passes++;
    checks++; if (o_m_axis_tdata !== 8'h00) $display("FAIL rst_mid_tdata: got %h need 00", o_m_axis_tdata); else passes++;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_m_axis_tready = 1'b1;
    @(posedge i_clk);
    base = out_q.size();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'hBD);
    idle(4);
    got = (base < out_q.size()) ? out_q[base] : 9'h1FF;
    checks++; if (out_q.size() - base != 1) $display("FAIL rst_after_count: got %0d need 1", out_q.size() - base); else passes++;
    checks++; if (got !== 9'h142) $display("FAIL rst_after_byte: got %h need 142", got); else passes++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_err();
    test_garbage();
    test_timeout();
    test_backpressure_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
